alu_pipe_ctrl: RTL and testbench
================================

Name: alu_pipe_ctrl

Overview:
- Parametrised, pipelined successor to the fixed-operand ALU control wrapper.
- Accepts operand/opcode requests over a valid/ready handshake, then computes one of eight ALU ops at WIDTH bits.
- Returns a registered result plus flags over a second valid/ready handshake.
- Keeps sticky flags and a completed-operation counter for the surrounding datapath and debug logic.

Parameters:
- WIDTH, 8: operand and result width in bits, 2 or more.
- CNT_W, 16: width of the completed-operation counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid and in_ready are both high.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_op  in  3  opcode.
- in_acc  in  1  use accumulator as A; only takes effect under ALU_ACC_EN.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_result  out  WIDTH  result.
- out_carry  out  1  carry/borrow/shift-out flag.
- out_zero  out  1  result equals 0.
- out_ovf  out  1  signed overflow.
- out_neg  out  1  result MSB.
- sticky_flags  out  4  OR-accumulated {carry, zero, ovf, neg}.
- clr_sticky  in  1  clear sticky_flags.
- op_count  out  CNT_W  number of results produced.

Behaviour:
- Reset: every output register is 0: out_valid, out_result, all flags, sticky_flags, op_count, the stage-1 valid, and the accumulator. in_ready is 1 after reset.
- Stage 1 (S1) registers in_a, in_b, in_op and in_acc on acceptance.
- Stage 2 (S2) computes from the S1 contents and loads the output registers.
- Latency: a request accepted at cycle N gives out_valid at N+2 when there is no stall.
- Throughput: one request per cycle.
- S1 advances into S2 when s1_valid is high and either out_valid is low or out_ready is high.
- in_ready = (not s1_valid) or S1-advance. No combinational path exists from in_valid to in_ready.
- Backpressure: while out_valid is high and out_ready is low:
  - out_result and the flags hold stable;
  - S1 holds its contents;
  - in_ready drops once S1 is full.
- Opcodes (results taken mod 2^WIDTH):
  - 000 ADD: A+B. carry = carry out of the MSB. ovf = signed overflow.
  - 001 SUB: A-B. carry = borrow, i.e. 1 when A < B unsigned. ovf = signed overflow.
  - 010 AND, 011 OR, 100 XOR: carry = 0, ovf = 0.
  - 101 NOT A: carry = 0, ovf = 0.
  - 110 SHL A by 1: carry = old A[WIDTH-1]. ovf = 0.
  - 111 SHR A by 1, logical: carry = old A[0]. ovf = 0.
- zero and neg are derived from the result for every opcode.
- A result is "produced" in the cycle S2 loads the output registers. On each produced result:
  - op_count increments and wraps at 2^CNT_W to 0;
  - sticky_flags |= new flags.
- clr_sticky:
  - Alone, it sets sticky_flags to 0 on the next edge.
  - In the same cycle as a produced result, sticky_flags becomes exactly the new flags (clear first, then set).
- Reset asserted mid-operation drops all in-flight requests immediately. No partial result is emitted after reset.

Optional Feature:
- Macro: ALU_ACC_EN.
- Defined:
  - A WIDTH-bit accumulator loads out_result's new value on every produced result.
  - When the S1 entry has in_acc = 1, S2 uses the accumulator as A and ignores in_a. This includes back-to-back requests, because S2 reads the accumulator as it was before the current load.
- Undefined: in_acc is ignored, no accumulator register exists, and A is always in_a.

Decomposition:
- Package alu_pkg holds:
  - the opcode localparams OP_ADD..OP_SHR;
  - flag index constants FLG_C=3, FLG_Z=2, FLG_V=1, FLG_N=0.
- Sub-module alu_core: purely combinational, parametrised by WIDTH, maps (a, b, op) to (result, carry, zero, ovf, neg).
- alu_pipe_ctrl holds:
  - the pipeline registers and handshake logic;
  - sticky_flags and op_count;
  - the accumulator, under ALU_ACC_EN.

Test Plan:
- WIDTH=8, out_ready=1:
  - ADD 0xFF+0x01 -> result 0x00, carry=1, zero=1, ovf=0, neg=0, 2 cycles after acceptance.
  - ADD 0x7F+0x01 -> 0x80, ovf=1, neg=1, carry=0.
- SUB 0x03-0x05 -> 0xFE, carry=1, neg=1.
- SHL 0x81 -> 0x02, carry=1.
- SHR 0x01 -> 0x00, carry=1, zero=1.
- Backpressure: hold out_ready=0 for 5 cycles while streaming 3 requests.
  - in_ready drops after S1 fills.
  - The result holds stable.
  - After release, all 3 results emerge in order with no loss or duplication, and op_count=3.
- Sticky clear: clr_sticky pulsed in the same cycle as a result with zero=1, where sticky was previously 4'b1000 -> sticky_flags=4'b0100.
- Counter wrap: CNT_W=2, 5 results -> op_count=1.
- Reset mid-stream: assert rst while S1 and S2 are full -> out_valid=0 and op_count=0 immediately; no stale result after release.
- ALU_ACC_EN defined: back-to-back ADD A=5,B=3 then ADD in_acc=1,B=2 -> results 8 and then 10.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode and flag-index constants for the pipelined ALU
//               control block (alu_core, alu_pipe_ctrl).
// Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    // 3-bit ALU opcodes
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    // Bit positions inside the 4-bit {carry, zero, ovf, neg} flag vector
    localparam int FLG_C = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_V = 1;
    localparam int FLG_N = 0;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Purely combinational WIDTH-bit ALU. Maps (a, b, op) to a
//               result plus carry/zero/overflow/negative flags.
// Ports       : a, b    - operands (WIDTH)
//               op      - opcode (3), see alu_pkg
//               result  - result mod 2^WIDTH
//               carry   - ADD carry-out, SUB borrow, shift-out bit, else 0
//               zero    - result == 0
//               ovf     - signed overflow for ADD/SUB, else 0
//               neg     - result MSB
// Revision    : 1.0  initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             ovf,
    output logic             neg
);

    localparam int c_msb = WIDTH - 1;

    // One extra bit so the ADD carry-out / SUB borrow falls out of the sum
    logic [WIDTH:0] w_ext;

    always_comb begin
        w_ext  = '0;
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (op)
            OP_ADD: begin
                w_ext  = {1'b0, a} + {1'b0, b};
                result = w_ext[WIDTH-1:0];
                carry  = w_ext[WIDTH];
                // Same-sign operands producing an opposite-sign result
                ovf    = (a[c_msb] == b[c_msb]) && (result[c_msb] != a[c_msb]);
            end
            OP_SUB: begin
                // Top bit of the zero-extended difference is the unsigned borrow
                w_ext  = {1'b0, a} - {1'b0, b};
                result = w_ext[WIDTH-1:0];
                carry  = w_ext[WIDTH];
                ovf    = (a[c_msb] != b[c_msb]) && (result[c_msb] != a[c_msb]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SHL: begin
                result = {a[WIDTH-2:0], 1'b0};
                carry  = a[c_msb];
            end
            OP_SHR: begin
                result = {1'b0, a[WIDTH-1:1]};
                carry  = a[0];
            end
            default: result = '0;
        endcase
        zero = (result == '0);
        neg  = result[c_msb];
    end

endmodule : alu_core
`default_nettype wire

// File: rtl/alu_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe_ctrl
// Description : Two-stage pipelined ALU wrapper with valid/ready handshakes on
//               input and output, sticky flags and a result counter.
//               S1 captures the request; S2 computes and loads the output
//               registers. One request per cycle, 2-cycle latency.
// Ports       : clk, rst                 - clock, async active-high reset
//               in_valid/in_ready        - request handshake
//               in_a, in_b, in_op, in_acc- request payload
//               out_valid/out_ready      - result handshake
//               out_result, out_carry, out_zero, out_ovf, out_neg - result
//               sticky_flags, clr_sticky - OR-accumulated {C,Z,V,N} and clear
//               op_count                 - results produced (wraps)
// Options     : ALU_ACC_EN - adds a WIDTH-bit accumulator; requests with
//               in_acc=1 use it in place of in_a.
// Revision    : 1.0  initial release
// ============================================================================
module alu_pipe_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_ovf,
    output logic             out_neg,
    output logic [3:0]       sticky_flags,
    input  logic             clr_sticky,
    output logic [CNT_W-1:0] op_count
);

    // ---------------- Stage 1 registers ----------------
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [2:0]       r_s1_op;

    logic             w_s1_adv;
    logic             w_accept;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic             w_zero;
    logic             w_ovf;
    logic             w_neg;
    logic [3:0]       w_flags;

    // S1 moves into S2 whenever the output register is free or being drained.
    // in_ready depends only on state and out_ready, never on in_valid.
    assign w_s1_adv = r_s1_valid && (!out_valid || out_ready);
    assign in_ready = !r_s1_valid || w_s1_adv;
    assign w_accept = in_valid && in_ready;

`ifdef ALU_ACC_EN
    logic             r_s1_acc;
    logic [WIDTH-1:0] r_acc;

    // r_acc still holds the previous result here, so back-to-back
    // accumulator requests chain correctly.
    assign w_op_a = r_s1_acc ? r_acc : r_s1_a;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_acc <= 1'b0;
            r_acc    <= '0;
        end else begin
            if (w_accept) begin
                r_s1_acc <= in_acc;
            end
            if (w_s1_adv) begin
                r_acc <= w_result;
            end
        end
    end
`else
    logic w_unused_acc;
    assign w_unused_acc = in_acc;
    assign w_op_a       = r_s1_a;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= '0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_a     <= in_a;
                r_s1_b     <= in_b;
                r_s1_op    <= in_op;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // ---------------- Stage 2: compute ----------------
    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .a      (w_op_a),
        .b      (r_s1_b),
        .op     (r_s1_op),
        .result (w_result),
        .carry  (w_carry),
        .zero   (w_zero),
        .ovf    (w_ovf),
        .neg    (w_neg)
    );

    always_comb begin
        w_flags        = 4'b0000;
        w_flags[FLG_C] = w_carry;
        w_flags[FLG_Z] = w_zero;
        w_flags[FLG_V] = w_ovf;
        w_flags[FLG_N] = w_neg;
    end

    // ---------------- Stage 2: output registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_carry    <= 1'b0;
            out_zero     <= 1'b0;
            out_ovf      <= 1'b0;
            out_neg      <= 1'b0;
            sticky_flags <= 4'b0000;
            op_count     <= '0;
        end else begin
            if (w_s1_adv) begin
                out_valid  <= 1'b1;
                out_result <= w_result;
                out_carry  <= w_carry;
                out_zero   <= w_zero;
                out_ovf    <= w_ovf;
                out_neg    <= w_neg;
                op_count   <= op_count + 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // Clear takes priority over the old value, then new flags are OR'd in
            if (clr_sticky || w_s1_adv) begin
                sticky_flags <= (clr_sticky ? 4'b0000 : sticky_flags)
                              | (w_s1_adv   ? w_flags : 4'b0000);
            end
        end
    end

endmodule : alu_pipe_ctrl
`default_nettype wire

// File: tb/tb_alu_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_pipe_ctrl
// Description : Directed self-checking bench for alu_pipe_ctrl (WIDTH=8).
//               A second instance with CNT_W=2 shares all inputs to observe
//               counter wrap. Accumulator steps run when ALU_ACC_EN is set.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [2:0] in_op;
    logic       in_acc;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic       out_carry;
    logic       out_zero;
    logic       out_ovf;
    logic       out_neg;
    logic [3:0] sticky_flags;
    logic       clr_sticky;
    logic [15:0] op_count;

    logic       w2_in_ready;
    logic       w2_out_valid;
    logic [7:0] w2_out_result;
    logic       w2_c, w2_z, w2_v, w2_n;
    logic [3:0] w2_sticky;
    logic [1:0] w2_op_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_pipe_ctrl #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_carry(out_carry), .out_zero(out_zero), .out_ovf(out_ovf),
        .out_neg(out_neg), .sticky_flags(sticky_flags),
        .clr_sticky(clr_sticky), .op_count(op_count)
    );

    alu_pipe_ctrl #(.WIDTH(8), .CNT_W(2)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w2_in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc),
        .out_valid(w2_out_valid), .out_ready(out_ready), .out_result(w2_out_result),
        .out_carry(w2_c), .out_zero(w2_z), .out_ovf(w2_v),
        .out_neg(w2_n), .sticky_flags(w2_sticky),
        .clr_sticky(clr_sticky), .op_count(w2_op_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single request with out_ready=1; checks latency, result and {C,Z,V,N}.
    // clr pulses clr_sticky in the cycle the result is produced.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic clr, input logic [7:0] exp_res,
                          input logic [3:0] exp_flg);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_acc   = 1'b0;
        step();                     // accepted at this edge
        in_valid   = 1'b0;
        check({tag, ".lat"}, {31'd0, out_valid}, 32'd0);
        clr_sticky = clr;
        step();                     // S2 loads at this edge
        clr_sticky = 1'b0;
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".res"},   {24'd0, out_result}, {24'd0, exp_res});
        check({tag, ".flags"}, {28'd0, out_carry, out_zero, out_ovf, out_neg},
              {28'd0, exp_flg});
    endtask

    initial begin
        logic [7:0] exp_q [3];
        int tx;
        int rx;
        bit saw_low;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
        in_acc = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst.result",  {24'd0, out_result}, 32'd0);
        check("rst.sticky",  {28'd0, sticky_flags}, 32'd0);
        check("rst.count",   {16'd0, op_count}, 32'd0);
        check("rst.in_ready", {31'd0, in_ready}, 32'd1);

        // Arithmetic and shift corner cases; flags are {C,Z,V,N}
        run_op("add_ff_01", 3'b000, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b1100);
        run_op("add_7f_01", 3'b000, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b0011);
        run_op("sub_03_05", 3'b001, 8'h03, 8'h05, 1'b0, 8'hFE, 4'b1001);
        run_op("shl_81",    3'b110, 8'h81, 8'h00, 1'b0, 8'h02, 4'b1000);
        run_op("shr_01",    3'b111, 8'h01, 8'h00, 1'b0, 8'h00, 4'b1100);
        check("count5",      {16'd0, op_count}, 32'd5);
        check("wrap_cnt2",   {30'd0, w2_op_count}, 32'd1);
        run_op("xor_f0_ff", 3'b100, 8'hF0, 8'hFF, 1'b0, 8'h0F, 4'b0000);
        run_op("not_55",    3'b101, 8'h55, 8'h00, 1'b0, 8'hAA, 4'b0001);
        run_op("sub_80_01", 3'b001, 8'h80, 8'h01, 1'b0, 8'h7F, 4'b0010);
        check("sticky_all",  {28'd0, sticky_flags}, 32'hF);

        // Sticky clear alone, then clear coinciding with a zero result
        step();
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        check("sticky_clr",  {28'd0, sticky_flags}, 32'h0);
        run_op("shl_81b",   3'b110, 8'h81, 8'h00, 1'b0, 8'h02, 4'b1000);
        check("sticky_c",    {28'd0, sticky_flags}, 32'h8);
        run_op("add_00_00", 3'b000, 8'h00, 8'h00, 1'b1, 8'h00, 4'b0100);
        check("sticky_clrset", {28'd0, sticky_flags}, 32'h4);
        check("count10",     {16'd0, op_count}, 32'd10);

        // Backpressure: 3 streamed requests, out_ready low for 5 cycles
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q[0] = 8'h02; exp_q[1] = 8'h04; exp_q[2] = 8'h06;
        tx = 0; rx = 0; saw_low = 1'b0;
        for (int c = 0; c < 12; c++) begin
            out_ready = (c < 5) ? 1'b0 : 1'b1;
            in_valid  = (tx < 3);
            in_op     = 3'b000;
            in_a      = 8'(tx + 1);
            in_b      = 8'(tx + 1);
            #1;
            if (!in_ready) saw_low = 1'b1;
            if (out_valid && !out_ready)
                check("bp.hold", {24'd0, out_result}, 32'h02);
            if (out_valid && out_ready) begin
                if (rx < 3) check("bp.order", {24'd0, out_result}, {24'd0, exp_q[rx]});
                rx++;
            end
            if (in_valid && in_ready) tx++;
            step();
        end
        in_valid = 1'b0;
        check("bp.in_ready_low", {31'd0, saw_low}, 32'd1);
        check("bp.rx",     rx, 32'd3);
        check("bp.count",  {16'd0, op_count}, 32'd3);
        check("bp.drained", {31'd0, out_valid}, 32'd0);

        // Reset while both stages hold requests
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op = 3'b000; in_a = 8'h11; in_b = 8'h11;
        step();
        step();
        in_valid = 1'b0;
        check("mid.full_valid", {31'd0, out_valid}, 32'd1);
        check("mid.full_ready", {31'd0, in_ready}, 32'd0);
        #2 rst = 1'b1;
        #1;
        check("mid.rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid.rst_count", {16'd0, op_count}, 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            check("mid.no_stale", {31'd0, out_valid}, 32'd0);
        end
        check("mid.count_after", {16'd0, op_count}, 32'd0);

`ifdef ALU_ACC_EN
        // Back-to-back: 5+3, then acc+2 with a junk in_a that must be ignored
        in_valid = 1'b1; in_op = 3'b000; in_a = 8'd5; in_b = 8'd3; in_acc = 1'b0;
        step();
        in_a = 8'hEE; in_b = 8'd2; in_acc = 1'b1;
        step();
        in_valid = 1'b0; in_acc = 1'b0;
        check("acc.first",  {24'd0, out_result}, 32'd8);
        step();
        check("acc.second", {24'd0, out_result}, 32'd10);
        check("acc.valid",  {31'd0, out_valid}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_alu_pipe_ctrl
`default_nettype wire
